// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter with an internal FIFO, 8N1 LSB-first framing on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_w_enable,
    input  logic [7:0] uart_w_data,
    output logic       uart_w_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    state_e           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic       empty, full, push, pop, bit_end;
    logic [7:0] head;

    // Full when the wrap bits differ but the addresses match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign push    = uart_w_enable && !full;
    assign bit_end = (baud_q == BAUD_LAST);
    assign pop     = !empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
    assign head    = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign uart_w_ready = !full;
    assign tx           = tx_q;
    assign busy         = (state_q != ST_IDLE) || !empty;
    assign dbg_state_o  = state_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= uart_w_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q      <= 1'b1;
                    baud_q    <= '0;
                    bit_idx_q <= '0;
                    if (pop) begin
                        shift_q <= head;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^head;
`endif
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (pop) begin
                            shift_q <= head;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^head;
`endif
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level line model predicts tx/busy/ready every cycle.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_w_enable = 1'b0;
    logic [7:0] uart_w_data = 8'h00;
    logic       uart_w_ready, tx, busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: queued bytes plus the remaining cycles of the frame on the line.
    logic [7:0]  exp_q[$];
    int          m_left = 0;
    logic [10:0] m_frame = '1;
    logic        m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b1;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .uart_w_enable(uart_w_enable), .uart_w_data(uart_w_data),
        .uart_w_ready(uart_w_ready), .tx(tx), .busy(busy),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_left  = 0;
        m_tx    = 1'b1;
        m_busy  = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] d);
        logic       acc;
        logic [7:0] b;
        acc = (exp_q.size() != D);
        if (m_left <= 1 && exp_q.size() != 0) begin
            b       = exp_q.pop_front();
            m_frame = make_frame(b);
            m_left  = FRAME_CYC;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (en && acc) exp_q.push_back(d);
        m_tx    = (m_left == 0) ? 1'b1 : m_frame[(FRAME_CYC - m_left) / C];
        m_busy  = (m_left != 0) || (exp_q.size() != 0);
        m_ready = (exp_q.size() != D);
    endtask

    task automatic step(input logic en, input logic [7:0] d);
        uart_w_enable = en;
        uart_w_data   = d;
        @(posedge clk);
        model_edge(en, d);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if ({tx, busy, uart_w_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_hold tx/busy/ready got %b%b%b exp 101", tx, busy, uart_w_ready);
        end
        n_checks++;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (10) begin
            step(1'b0, 8'h00);
            if ({tx, busy, uart_w_ready} !== 3'b101) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d tx/busy/ready got %b%b%b exp 101",
                         cyc, tx, busy, uart_w_ready);
            end
            n_checks++;
        end
    endtask

    task automatic test_single();
        int push_cyc, fall_cyc, bfall_cyc;
        fall_cyc  = -1;
        bfall_cyc = -1;
        step(1'b1, 8'h55);
        push_cyc = cyc;
        repeat (FRAME_CYC + 8) begin
            step(1'b0, 8'h00);
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL single_line cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
            if (fall_cyc < 0 && tx === 1'b0) fall_cyc = cyc;
            if (fall_cyc >= 0 && bfall_cyc < 0 && busy === 1'b0) bfall_cyc = cyc;
        end
        if (fall_cyc != push_cyc + 1) begin
            n_fail++;
            $display("FAIL single_latency tx fell at cyc %0d exp %0d", fall_cyc, push_cyc + 1);
        end
        n_checks++;
        if (bfall_cyc != push_cyc + 1 + FRAME_CYC) begin
            n_fail++;
            $display("FAIL single_busy_fall at cyc %0d exp %0d", bfall_cyc, push_cyc + 1 + FRAME_CYC);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        int p, k;
        logic tx_before, tx_at;
        tx_before = 1'bx;
        tx_at     = 1'bx;
        step(1'b1, 8'hA3);
        p = cyc;
        step(1'b1, 8'h0F);
        repeat (2 * FRAME_CYC + 8) begin
            step(1'b0, 8'h00);
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL b2b_line cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
            k = cyc - (p + 1);
            if (k == FRAME_CYC - 1) tx_before = tx;
            if (k == FRAME_CYC)     tx_at     = tx;
            if (k == 2 * FRAME_CYC - 1 && busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_busy_early cyc=%0d got %b exp 1", cyc, busy);
            end
            if (k == 2 * FRAME_CYC - 1) n_checks++;
            if (k == 2 * FRAME_CYC && busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_busy_end cyc=%0d got %b exp 0", cyc, busy);
            end
            if (k == 2 * FRAME_CYC) n_checks++;
        end
        if ({tx_before, tx_at} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_gap stop/start got %b%b exp 10", tx_before, tx_at);
        end
        n_checks++;
    endtask

    task automatic test_overflow();
        int p, rise_cyc, bfall_cyc;
        rise_cyc  = -1;
        bfall_cyc = -1;
        p = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)));
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL ovf_push cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
            if (i >= 4 && uart_w_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_ready_low push=%0d got %b exp 0", i + 1, uart_w_ready);
            end
            if (i >= 4) n_checks++;
        end
        repeat (5 * FRAME_CYC + 8) begin
            step(1'b0, 8'h00);
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL ovf_line cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
            if (rise_cyc < 0 && uart_w_ready === 1'b1) rise_cyc = cyc;
            if (bfall_cyc < 0 && busy === 1'b0) bfall_cyc = cyc;
        end
        if (rise_cyc != p + 1 + FRAME_CYC) begin
            n_fail++;
            $display("FAIL ovf_ready_rise at cyc %0d exp %0d", rise_cyc, p + 1 + FRAME_CYC);
        end
        n_checks++;
        if (bfall_cyc != p + 1 + 5 * FRAME_CYC) begin
            n_fail++;
            $display("FAIL ovf_five_frames busy fell at cyc %0d exp %0d", bfall_cyc, p + 1 + 5 * FRAME_CYC);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        int p, lows;
        lows = 0;
        step(1'b1, 8'hFF);
        p = cyc;
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        while (cyc < p + 18) begin
            step(1'b0, 8'h00);
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL rmid_pre cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        if ({tx, busy, uart_w_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL rmid_abort tx/busy/ready got %b%b%b exp 101", tx, busy, uart_w_ready);
        end
        n_checks++;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2 * FRAME_CYC) begin
            step(1'b0, 8'h00);
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL rmid_post cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
            if (tx !== 1'b1) lows++;
        end
        if (lows != 0) begin
            n_fail++;
            $display("FAIL rmid_silent low samples got %0d exp 0", lows);
        end
        n_checks++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       par_exp [2];
        int p, k, bfall;
        logic par_seen;
        bytes[0] = 8'h07; par_exp[0] = 1'b1;
        bytes[1] = 8'h03; par_exp[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            bfall    = -1;
            par_seen = 1'bx;
            step(1'b1, bytes[j]);
            p = cyc;
            repeat (FRAME_CYC + 6) begin
                step(1'b0, 8'h00);
                if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                    n_fail++;
                    $display("FAIL par_line cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                             cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
                end
                n_checks++;
                k = cyc - (p + 1);
                if (k == 9 * C + 1) par_seen = tx;
                if (bfall < 0 && busy === 1'b0) bfall = cyc;
            end
            if (par_seen !== par_exp[j]) begin
                n_fail++;
                $display("FAIL par_bit byte=%h got %b exp %b", bytes[j], par_seen, par_exp[j]);
            end
            n_checks++;
            if (bfall != p + 1 + 44) begin
                n_fail++;
                $display("FAIL par_frame_len busy fell at cyc %0d exp %0d", bfall, p + 45);
            end
            n_checks++;
        end
    endtask
`endif

    task automatic test_random();
        logic en;
        for (int i = 0; i < 600; i++) begin
            en = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            step(en, 8'($urandom_range(0, 255)));
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL rand_line cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
        end
        repeat ((D + 2) * FRAME_CYC) begin
            step(1'b0, 8'h00);
            if ({tx, busy, uart_w_ready} !== {m_tx, m_busy, m_ready}) begin
                n_fail++;
                $display("FAIL rand_drain cyc=%0d tx/busy/ready got %b%b%b exp %b%b%b",
                         cyc, tx, busy, uart_w_ready, m_tx, m_busy, m_ready);
            end
            n_checks++;
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drained busy got %b exp 0", busy);
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
